// File: rtl/retire_map.sv
// -----------------------------------------------------------------------------
// retire_map
//
// Retirement (architectural) map table. Up to N instructions retire per cycle
// from the ROB head. Each active lane commits its new physical destination
// into the architectural map, and the physical register it displaces is handed
// back to the free list, compacted from lane 0.
//
// A lane is active when it is within retire_num, writes a destination, and
// that destination is not architectural register 0. Inactive lanes inside
// retire_num still count toward retire_cnt.
//
// Build option:
//   RETIRE_MAP_REG_OUT_EN  defined     : free_num/free_reg are registered and
//                                        appear one cycle after the retire.
//                          not defined : free_num/free_reg are combinational
//                                        from the current inputs and arch_map.
//
// Ports:
//   clock        in   clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   retire_num   in   number of retiring lanes (values above N are clamped)
//   retire_dest  in   per lane: instruction writes a destination register
//   retire_ar    in   per lane: architectural destination register
//   retire_pr    in   per lane: new physical destination register
//   free_num     out  number of registers returned this cycle
//   free_reg     out  returned registers, each packet {reg_idx, valid}
//   arch_map     out  committed arch->phys map (registered state)
//   retire_cnt   out  total retired instructions, wraps at 2^32
// -----------------------------------------------------------------------------
module retire_map #(
    parameter int N           = 3,
    parameter int ARCH_REG_SZ = 32,
    parameter int PHYS_REG_SZ = 64,
    localparam int AR_W  = $clog2(ARCH_REG_SZ),
    localparam int PR_W  = $clog2(PHYS_REG_SZ),
    localparam int NUM_W = $clog2(N + 1),
    localparam int PKT_W = PR_W + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_W-1:0]                     retire_num,
    input  logic [N-1:0]                         retire_dest,
    input  logic [N-1:0][AR_W-1:0]               retire_ar,
    input  logic [N-1:0][PR_W-1:0]               retire_pr,
    output logic [NUM_W-1:0]                     free_num,
    output logic [N-1:0][PKT_W-1:0]              free_reg,
    output logic [ARCH_REG_SZ-1:0][PR_W-1:0]     arch_map,
    output logic [31:0]                          retire_cnt
);

    logic [ARCH_REG_SZ-1:0][PR_W-1:0] map_q;
    logic [ARCH_REG_SZ-1:0][PR_W-1:0] map_d;
    logic [31:0]                      cnt_q;
    logic [31:0]                      cnt_d;

    logic [NUM_W-1:0]                 num_eff;
    logic [N-1:0]                     active;
    logic [PR_W-1:0]                  old_pr [N];
    logic [NUM_W-1:0]                 free_num_d;
    logic [N-1:0][PKT_W-1:0]          free_reg_d;

    always_comb begin
        num_eff = retire_num;
        if (int'(retire_num) > N) begin
            num_eff = NUM_W'(N);
        end
    end

    // Active-lane qualification and displaced-register lookup. Gating with
    // reset keeps the combinational free outputs quiet in the reset cycle.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign active[gi] = !reset && (int'(num_eff) > gi) && retire_dest[gi]
                            && (retire_ar[gi] != '0);

        // The youngest older lane in the same group that writes the same
        // arch reg supersedes the committed map entry.
        always_comb begin
            old_pr[gi] = map_q[retire_ar[gi]];
            for (int j = 0; j < gi; j++) begin
                if (active[j] && (retire_ar[j] == retire_ar[gi])) begin
                    old_pr[gi] = retire_pr[j];
                end
            end
        end
    end

    // Later lanes overwrite earlier ones, so the youngest writer wins.
    always_comb begin
        map_d = map_q;
        for (int i = 0; i < N; i++) begin
            if (active[i]) begin
                map_d[retire_ar[i]] = retire_pr[i];
            end
        end
    end

    // Compact displaced registers of active lanes from slot 0, in lane order.
    always_comb begin
        free_num_d = '0;
        free_reg_d = '0;
        for (int i = 0; i < N; i++) begin
            if (active[i]) begin
                free_reg_d[free_num_d] = {old_pr[i], 1'b1};
                free_num_d             = free_num_d + NUM_W'(1);
            end
        end
    end

    assign cnt_d = cnt_q + 32'(num_eff);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                map_q[i] <= PR_W'(i);
            end
            cnt_q <= '0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
        end
    end

    assign arch_map   = map_q;
    assign retire_cnt = cnt_q;

`ifdef RETIRE_MAP_REG_OUT_EN
    logic [NUM_W-1:0]        free_num_q;
    logic [N-1:0][PKT_W-1:0] free_reg_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            free_num_q <= '0;
            free_reg_q <= '0;
        end else begin
            free_num_q <= free_num_d;
            free_reg_q <= free_reg_d;
        end
    end

    assign free_num = free_num_q;
    assign free_reg = free_reg_q;
`else
    assign free_num = free_num_d;
    assign free_reg = free_reg_d;
`endif

endmodule

// File: tb/tb_retire_map.sv
// -----------------------------------------------------------------------------
// tb_retire_map
//
// Bench for retire_map with N=3, ARCH_REG_SZ=32, PHYS_REG_SZ=64. The reference
// model walks each retire group lane by lane in program order against a plain
// int array, which yields the displaced registers, forwarding and final map
// directly from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_retire_map;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        retire_num;
    logic [2:0]        retire_dest;
    logic [2:0][4:0]   retire_ar;
    logic [2:0][5:0]   retire_pr;
    logic [1:0]        free_num;
    logic [2:0][6:0]   free_reg;
    logic [31:0][5:0]  arch_map;
    logic [31:0]       retire_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state (post-edge view) and expected free output.
    int               mmap [32];
    logic [31:0]      mcnt;
    int               exp_fnum;
    logic [2:0][6:0]  exp_freg;
    logic [31:0][5:0] exp_map;

    retire_map #(.N(3), .ARCH_REG_SZ(32), .PHYS_REG_SZ(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .retire_num  (retire_num),
        .retire_dest (retire_dest),
        .retire_ar   (retire_ar),
        .retire_pr   (retire_pr),
        .free_num    (free_num),
        .free_reg    (free_reg),
        .arch_map    (arch_map),
        .retire_cnt  (retire_cnt)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs at the falling edge and advance the model.
    task automatic apply(input bit rst, input int num, input logic [2:0] dest,
                         input logic [2:0][4:0] ar, input logic [2:0][5:0] pr);
        int n;
        @(negedge clock);
        reset       = rst;
        retire_num  = 2'(num);
        retire_dest = dest;
        retire_ar   = ar;
        retire_pr   = pr;
        exp_fnum    = 0;
        exp_freg    = '0;
        if (rst) begin
            for (int i = 0; i < 32; i++) mmap[i] = i;
            mcnt = 32'd0;
        end else begin
            n = (num > 3) ? 3 : num;
            for (int i = 0; i < 3; i++) begin
                if (i < n && dest[i] && ar[i] != 5'd0) begin
                    exp_freg[exp_fnum] = {6'(mmap[ar[i]]), 1'b1};
                    exp_fnum++;
                    mmap[ar[i]] = int'(pr[i]);
                end
            end
            mcnt = mcnt + 32'(n);
        end
        for (int i = 0; i < 32; i++) exp_map[i] = 6'(mmap[i]);
    endtask

    task automatic test_reset;
        reset = 1'b1; retire_num = 2'd0; retire_dest = '0; retire_ar = '0; retire_pr = '0;
        repeat (2) @(posedge clock);
        apply(1'b0, 0, 3'b000, '0, '0);
        apply(1'b0, 0, 3'b000, '0, '0);
        @(posedge clock); #1;
        total++;
        if (arch_map[5] !== 6'd5) begin
            bad++; $display("FAIL reset_map5 got=%0d want=5", arch_map[5]);
        end
        total++;
        if (free_num !== 2'd0 || free_reg !== '0) begin
            bad++; $display("FAIL reset_free got num=%0d reg=%h want num=0 reg=0", free_num, free_reg);
        end
        total++;
        if (retire_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d want=0", retire_cnt);
        end
        $display("reset: map5=%0d free_num=%0d cnt=%0d", arch_map[5], free_num, retire_cnt);
    endtask

    task automatic test_single;
        apply(1'b0, 1, 3'b001, {5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd40});
`ifndef RETIRE_MAP_REG_OUT_EN
        #1;
`else
        @(posedge clock); #1;
`endif
        total++;
        if (free_num !== 2'd1 || free_reg[0] !== {6'd5, 1'b1} || free_reg[2:1] !== '0) begin
            bad++; $display("FAIL single_free got num=%0d reg=%h want num=1 reg0=%h", free_num, free_reg, {6'd5, 1'b1});
        end
`ifndef RETIRE_MAP_REG_OUT_EN
        @(posedge clock); #1;
`endif
        total++;
        if (arch_map[5] !== 6'd40) begin
            bad++; $display("FAIL single_map got=%0d want=40", arch_map[5]);
        end
        $display("single: free_num=%0d reg0=%h map5=%0d", free_num, free_reg[0], arch_map[5]);
    endtask

    task automatic test_intra_group;
        apply(1'b0, 3, 3'b111, {5'd7, 5'd3, 5'd3}, {6'd35, 6'd34, 6'd33});
`ifndef RETIRE_MAP_REG_OUT_EN
        #1;
`else
        @(posedge clock); #1;
`endif
        total++;
        if (free_num !== 2'd3 || free_reg !== {{6'd7, 1'b1}, {6'd33, 1'b1}, {6'd3, 1'b1}}) begin
            bad++; $display("FAIL intra_free got num=%0d reg=%h want num=3 regs=3,33,7", free_num, free_reg);
        end
`ifndef RETIRE_MAP_REG_OUT_EN
        @(posedge clock); #1;
`endif
        total++;
        if (arch_map[3] !== 6'd34 || arch_map[7] !== 6'd35) begin
            bad++; $display("FAIL intra_map got map3=%0d map7=%0d want 34 35", arch_map[3], arch_map[7]);
        end
        $display("intra: free_num=%0d regs=%h map3=%0d map7=%0d", free_num, free_reg, arch_map[3], arch_map[7]);
    endtask

    task automatic test_inactive;
        apply(1'b0, 3, 3'b110, {5'd9, 5'd0, 5'd4}, {6'd50, 6'd20, 6'd10});
`ifndef RETIRE_MAP_REG_OUT_EN
        #1;
`else
        @(posedge clock); #1;
`endif
        total++;
        if (free_num !== 2'd1 || free_reg !== {7'd0, 7'd0, {6'd9, 1'b1}}) begin
            bad++; $display("FAIL inactive_free got num=%0d reg=%h want num=1 reg0=%h", free_num, free_reg, {6'd9, 1'b1});
        end
`ifndef RETIRE_MAP_REG_OUT_EN
        @(posedge clock); #1;
`endif
        // 1 + 3 + 3 retired since reset.
        total++;
        if (retire_cnt !== 32'd7 || arch_map[9] !== 6'd50 || arch_map[4] !== 6'd4) begin
            bad++; $display("FAIL inactive_state got cnt=%0d map9=%0d map4=%0d want 7 50 4", retire_cnt, arch_map[9], arch_map[4]);
        end
        $display("inactive: free_num=%0d cnt=%0d map9=%0d", free_num, retire_cnt, arch_map[9]);
    endtask

    task automatic test_reset_override;
        logic [31:0][5:0] ident;
        for (int i = 0; i < 32; i++) ident[i] = 6'(i);
        apply(1'b1, 3, 3'b111, {5'd6, 5'd4, 5'd2}, {6'd43, 6'd42, 6'd41});
        #1;
        total++;
        if (free_num !== 2'd0 || free_reg !== '0) begin
            bad++; $display("FAIL rstov_free_comb got num=%0d reg=%h want 0", free_num, free_reg);
        end
        @(posedge clock); #1;
        total++;
        if (arch_map !== ident || retire_cnt !== 32'd0 || free_num !== 2'd0) begin
            bad++; $display("FAIL rstov_state got map2=%0d cnt=%0d num=%0d want identity 0 0", arch_map[2], retire_cnt, free_num);
        end
        apply(1'b0, 0, 3'b000, '0, '0);
        $display("reset_override: map2=%0d cnt=%0d free_num=%0d", arch_map[2], retire_cnt, free_num);
    endtask

    task automatic test_back_to_back;
        logic [6:0] obs_q[$];
        logic [6:0] exp_q[$];
        logic [2:0][4:0] ar;
        logic [2:0][5:0] pr;
        apply(1'b1, 0, 3'b000, '0, '0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                ar[i] = 5'($urandom_range(1, 31));
                pr[i] = 6'($urandom_range(0, 63));
            end
            apply(1'b0, 3, 3'b111, ar, pr);
            for (int i = 0; i < exp_fnum; i++) exp_q.push_back(exp_freg[i]);
`ifndef RETIRE_MAP_REG_OUT_EN
            #1;
`else
            @(posedge clock); #1;
`endif
            for (int i = 0; i < int'(free_num); i++) obs_q.push_back(free_reg[i]);
            $display("b2b cycle %0d: free_num=%0d regs=%h", k, free_num, free_reg);
        end
        apply(1'b0, 0, 3'b000, '0, '0);
`ifndef RETIRE_MAP_REG_OUT_EN
        @(posedge clock); #1;
`endif
        total++;
        if (retire_cnt !== 32'd12) begin
            bad++; $display("FAIL b2b_cnt got=%0d want=12", retire_cnt);
        end
        total++;
        if (obs_q.size() != 12) begin
            bad++; $display("FAIL b2b_count got=%0d want=12", obs_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL b2b_reg idx=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (arch_map !== exp_map) begin
            bad++; $display("FAIL b2b_map got=%h want=%h", arch_map, exp_map);
        end
    endtask

    task automatic test_random;
        logic [2:0][4:0] ar;
        logic [2:0][5:0] pr;
        logic [2:0]      dest;
        int              num;
        for (int k = 0; k < 300; k++) begin
            num  = $urandom_range(0, 3);
            dest = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                // Narrow range half the time so same-group collisions are common.
                ar[i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
                pr[i] = 6'($urandom_range(0, 63));
            end
            apply(1'b0, num, dest, ar, pr);
`ifndef RETIRE_MAP_REG_OUT_EN
            #1;
            total++;
            if (free_num !== 2'(exp_fnum) || free_reg !== exp_freg) begin
                bad++; $display("FAIL rand_free k=%0d got num=%0d reg=%h want num=%0d reg=%h", k, free_num, free_reg, exp_fnum, exp_freg);
            end
            @(posedge clock); #1;
`else
            @(posedge clock); #1;
            total++;
            if (free_num !== 2'(exp_fnum) || free_reg !== exp_freg) begin
                bad++; $display("FAIL rand_free k=%0d got num=%0d reg=%h want num=%0d reg=%h", k, free_num, free_reg, exp_fnum, exp_freg);
            end
`endif
            total++;
            if (arch_map !== exp_map) begin
                bad++; $display("FAIL rand_map k=%0d got=%h want=%h", k, arch_map, exp_map);
            end
            total++;
            if (retire_cnt !== mcnt) begin
                bad++; $display("FAIL rand_cnt k=%0d got=%0d want=%0d", k, retire_cnt, mcnt);
            end
            $display("rand %0d: num=%0d dest=%b ar=%h pr=%h -> free_num=%0d cnt=%0d", k, num, dest, ar, pr, free_num, retire_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mmap[i] = i;
        mcnt = 32'd0;
        test_reset;
        test_single;
        test_intra_group;
        test_inactive;
        test_reset_override;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
